// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command queue and issue stage.
package alu_pkg;

  localparam logic [3:0]  ALU_OP_MUL = 4'd2;
  localparam logic [3:0]  ALU_OP_ADD = 4'd3;
  localparam int unsigned ALU_RES_W  = 4;
  localparam int unsigned ALU_TAG_W  = 3;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] a;
    logic [1:0] b;
  } alu_cmd_t;

  localparam int unsigned ALU_CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with push/pop/full/empty; pushes when full and pops when empty are ignored.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Extra MSB on each pointer distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Command queue and issue stage in front of the 2-bit ALU, with a 2-entry in-order result buffer.
// Optional ALU_ISSUE_TAG_EN adds a 3-bit command tag returned on rsp_tag.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_a,
  input  logic [1:0]           cmd_b,
  input  logic [3:0]           cmd_op,
  output logic [1:0]           alu_a,
  output logic [1:0]           alu_b,
  output logic [3:0]           alu_operation,
  input  logic [ALU_RES_W-1:0] alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ALU_RES_W-1:0] rsp_data,
`ifdef ALU_ISSUE_TAG_EN
  output logic [ALU_TAG_W-1:0] rsp_tag,
`endif
  output logic                 idle
);

`ifdef ALU_ISSUE_TAG_EN
  localparam int unsigned FIFO_W = ALU_CMD_W + ALU_TAG_W;
`else
  localparam int unsigned FIFO_W = ALU_CMD_W;
`endif

  alu_cmd_t              w_cmd_in;
  alu_cmd_t              w_head_cmd;
  logic [FIFO_W-1:0]     w_fifo_din;
  logic [FIFO_W-1:0]     w_fifo_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_rsp_pop;
  logic [2:0]            w_credit_use;

  logic                  r_inflight;
  logic [ALU_RES_W-1:0]  r_res_data [2];
  logic                  r_res_wr;
  logic                  r_res_rd;
  logic [1:0]            r_res_count;

  assign w_cmd_in  = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_rsp_pop = rsp_valid && rsp_ready;

`ifdef ALU_ISSUE_TAG_EN
  logic [ALU_TAG_W-1:0] r_tag_cnt;
  logic [ALU_TAG_W-1:0] r_inflight_tag;
  logic [ALU_TAG_W-1:0] r_res_tag [2];

  assign w_fifo_din = {r_tag_cnt, w_cmd_in};
  assign w_head_cmd = alu_cmd_t'(w_fifo_head[ALU_CMD_W-1:0]);
  assign rsp_tag    = r_res_tag[r_res_rd];

  // Tag follows its command through FIFO, in-flight stage and result buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_cnt      <= '0;
      r_inflight_tag <= '0;
      r_res_tag[0]   <= '0;
      r_res_tag[1]   <= '0;
    end else begin
      if (w_push)     r_tag_cnt <= r_tag_cnt + ALU_TAG_W'(1);
      if (w_issue)    r_inflight_tag <= w_fifo_head[FIFO_W-1 -: ALU_TAG_W];
      if (r_inflight) r_res_tag[r_res_wr] <= r_inflight_tag;
    end
  end
`else
  assign w_fifo_din = w_cmd_in;
  assign w_head_cmd = alu_cmd_t'(w_fifo_head);
`endif

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_issue),
    .o_head  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Credit: buffered + in-flight results, minus this cycle's pop, must leave room for one more.
  assign w_credit_use = 3'({1'b0, r_res_count}) + 3'(r_inflight) - 3'(w_rsp_pop);
  assign w_issue      = !w_empty && (w_credit_use < 3'd2);

  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = '0;
    if (w_issue) begin
      alu_a         = w_head_cmd.a;
      alu_b         = w_head_cmd.b;
      alu_operation = w_head_cmd.op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight    <= 1'b0;
      r_res_wr      <= 1'b0;
      r_res_rd      <= 1'b0;
      r_res_count   <= '0;
      r_res_data[0] <= '0;
      r_res_data[1] <= '0;
    end else begin
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_res_data[r_res_wr] <= alu_out;
        r_res_wr             <= ~r_res_wr;
      end
      if (w_rsp_pop) r_res_rd <= ~r_res_rd;
      case ({r_inflight, w_rsp_pop})
        2'b10:   r_res_count <= r_res_count + 2'd1;
        2'b01:   r_res_count <= r_res_count - 2'd1;
        default: r_res_count <= r_res_count;
      endcase
    end
  end

  assign rsp_valid = (r_res_count != 2'd0);
  assign rsp_data  = r_res_data[r_res_rd];
  assign idle      = w_empty && !r_inflight && (r_res_count == 2'd0);

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue with a behavioural registered ALU.
// Define ALU_ISSUE_TAG_EN to also exercise the rsp_tag sequence.
module tb_alu_issue_queue;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic [3:0] cmd_op;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [3:0] alu_operation;
  logic [3:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       idle;
`ifdef ALU_ISSUE_TAG_EN
  logic [2:0] rsp_tag;
  logic [2:0] got_tag [$];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_issue = 0;
  logic [3:0] got_q   [$];
  int         got_cyc [$];

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_op        (cmd_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_operation (alu_operation),
    .alu_out       (alu_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
`ifdef ALU_ISSUE_TAG_EN
    .rsp_tag       (rsp_tag),
`endif
    .idle          (idle)
  );

  function automatic logic [3:0] alu_f(input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] op);
    logic [3:0] wa;
    logic [3:0] wb;
    wa = {2'b00, a};
    wb = {2'b00, b};
    case (op)
      4'd2:    return wa * wb;
      4'd3:    return wa + wb;
      default: return wa - wb + 4'd1;
    endcase
  endfunction

  // Registered ALU stand-in (no reset, like the real one).
  always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_operation);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst_n && alu_operation != 4'd0) n_issue <= n_issue + 1;
    if (rst_n && rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_data);
      got_cyc.push_back(cyc);
`ifdef ALU_ISSUE_TAG_EN
      got_tag.push_back(rsp_tag);
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [3:0] op,
                      output int acc);
    int guard;
    guard     = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("push_wait", 32'(guard < 50), 1);
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_idle"}, 32'(idle), 1);
    check({tag, "_alu_a"}, 32'(alu_a), 0);
    check({tag, "_alu_b"}, 32'(alu_b), 0);
    check({tag, "_alu_op"}, 32'(alu_operation), 0);
  endtask

  initial begin
    int acc;
    int dummy;
    int b;
    int base_issue;
    int guard;
    logic [3:0] exp_bp [7];
    logic [3:0] exp_bb [3];

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    rsp_ready = 1'b1;

    // Reset and idle
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("after_reset");

    // Single command: 3*3 = 9, three cycles after accept
    b = got_q.size();
    push(2'd3, 2'd3, 4'd2, acc);
    check("single_alu_a", 32'(alu_a), 3);
    check("single_alu_b", 32'(alu_b), 3);
    check("single_alu_op", 32'(alu_operation), 2);
    check("single_busy", 32'(idle), 0);
    @(negedge clk);
    check("single_n2_valid", 32'(rsp_valid), 0);
    check("single_n2_alu_op", 32'(alu_operation), 0);
    @(negedge clk);
    check("single_n3_valid", 32'(rsp_valid), 1);
    check("single_n3_data", 32'(rsp_data), 9);
    @(negedge clk);
    check("single_n4_valid", 32'(rsp_valid), 0);
    check("single_n4_idle", 32'(idle), 1);
    check("single_count", 32'(got_q.size() - b), 1);
    if (got_q.size() > b) check("single_latency", 32'(got_cyc[b] - acc), 3);

    // Back-to-back stream: 3+2=5, 0-1+1=0, 0-3+1=14
    exp_bb = '{4'd5, 4'd0, 4'd14};
    b = got_q.size();
    push(2'd3, 2'd2, 4'd3, dummy);
    push(2'd0, 2'd1, 4'd0, dummy);
    push(2'd0, 2'd3, 4'd7, dummy);
    repeat (6) @(negedge clk);
    check("b2b_count", 32'(got_q.size() - b), 3);
    if (got_q.size() >= b + 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("b2b_data%0d", i), 32'(got_q[b+i]), 32'(exp_bb[i]));
      check("b2b_gap1", 32'(got_cyc[b+1] - got_cyc[b]), 1);
      check("b2b_gap2", 32'(got_cyc[b+2] - got_cyc[b+1]), 1);
    end

    // Backpressure: only two issues, FIFO fills, then drain in order
    exp_bp = '{4'd2, 4'd4, 4'd0, 4'd6, 4'd4, 4'd15, 4'd4};
    rsp_ready  = 1'b0;
    b          = got_q.size();
    base_issue = n_issue;
    push(2'd1, 2'd2, 4'd2, dummy);
    push(2'd3, 2'd1, 4'd3, dummy);
    push(2'd2, 2'd3, 4'd1, dummy);
    push(2'd3, 2'd3, 4'd3, dummy);
    push(2'd2, 2'd2, 4'd2, dummy);
    push(2'd0, 2'd2, 4'd5, dummy);
    repeat (3) @(negedge clk);
    check("bp_issues", 32'(n_issue - base_issue), 2);
    check("bp_cmd_ready", 32'(cmd_ready), 0);
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    check("bp_head", 32'(rsp_data), 2);
    check("bp_busy", 32'(idle), 0);
    repeat (2) @(negedge clk);
    check("bp_head_stable", 32'(rsp_data), 2);
    check("bp_issues_stable", 32'(n_issue - base_issue), 2);
    rsp_ready = 1'b1;
    push(2'd3, 2'd0, 4'd4, dummy);
    guard = 0;
    while (got_q.size() < b + 7 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("bp_drain_count", 32'(got_q.size() - b), 7);
    if (got_q.size() >= b + 7)
      for (int i = 0; i < 7; i++) check($sformatf("bp_data%0d", i), 32'(got_q[b+i]), 32'(exp_bp[i]));
    check("bp_idle", 32'(idle), 1);

    // Reset with FIFO, in-flight stage and result buffer all occupied
    rsp_ready = 1'b0;
    push(2'd1, 2'd1, 4'd3, dummy);
    push(2'd2, 2'd1, 4'd3, dummy);
    push(2'd3, 2'd1, 4'd3, dummy);
    check("pre_rst_valid", 32'(rsp_valid), 1);
    check("pre_rst_busy", 32'(idle), 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    b = got_q.size();
    repeat (8) @(negedge clk);
    check("post_rst_no_rsp", 32'(got_q.size() - b), 0);
    check_reset_outputs("post_rst");

`ifdef ALU_ISSUE_TAG_EN
    // Tag sequence wraps 7 -> 0
    b = got_q.size();
    for (int i = 0; i < 10; i++) push(2'd1, 2'd1, 4'd3, dummy);
    repeat (6) @(negedge clk);
    check("tag_count", 32'(got_tag.size() - b), 10);
    if (got_tag.size() >= b + 10)
      for (int i = 0; i < 10; i++) begin
        check($sformatf("tag%0d", i), 32'(got_tag[b+i]), 32'(i % 8));
        check($sformatf("tag_data%0d", i), 32'(got_q[b+i]), 2);
      end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
